// File: rtl/mem_port_arbiter_if.sv
// Bundle of CPU fetch/data ports, unified-memory handshake and status outputs.
// slave = arbiter side, master = CPU/memory environment side.
interface mem_port_arbiter_if #(
  parameter int WORD_SIZE = 16
);
  logic                 i_readM;
  logic [WORD_SIZE-1:0] i_address;
  logic [WORD_SIZE-1:0] i_rdata;
  logic                 i_valid;
  logic                 i_stall;

  logic                 d_readM;
  logic                 d_writeM;
  logic [WORD_SIZE-1:0] d_address;
  logic [WORD_SIZE-1:0] d_wdata;
  logic [WORD_SIZE-1:0] d_rdata;
  logic                 d_valid;
  logic                 d_stall;

  logic                 mem_readM;
  logic                 mem_writeM;
  logic [WORD_SIZE-1:0] mem_address;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic [WORD_SIZE-1:0] mem_rdata;
  logic                 mem_ack;
  logic                 mem_err;

  logic [15:0]          i_stall_cycles;
  logic [15:0]          d_stall_cycles;

  modport slave (
    input  i_readM, i_address, d_readM, d_writeM, d_address, d_wdata,
           mem_rdata, mem_ack,
    output i_rdata, i_valid, i_stall, d_rdata, d_valid, d_stall,
           mem_readM, mem_writeM, mem_address, mem_wdata, mem_err,
           i_stall_cycles, d_stall_cycles
  );

  modport master (
    output i_readM, i_address, d_readM, d_writeM, d_address, d_wdata,
           mem_rdata, mem_ack,
    input  i_rdata, i_valid, i_stall, d_rdata, d_valid, d_stall,
           mem_readM, mem_writeM, mem_address, mem_wdata, mem_err,
           i_stall_cycles, d_stall_cycles
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the CPU fetch and data ports onto one single-ported memory with ack handshake.
// Define ARB_PERF_CNT_EN to build the saturating per-port stall-cycle counters.
module mem_port_arbiter #(
  parameter int WORD_SIZE     = 16,
  parameter int DATA_PRIORITY = 1,
  parameter int TIMEOUT       = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  mem_port_arbiter_if.slave     bus
);
  typedef enum logic [1:0] {IDLE, I_ACC, D_ACC, RESP} state_t;

  state_t     state_reg;
  logic [7:0] tcnt_reg;
  logic       served_d_reg;
  logic       rr_d_last_reg;

  logic d_req;
  logic d_win;
  logic acc_timeout;

  assign d_req = bus.d_readM | bus.d_writeM;
  // Round-robin: data takes a tie only when the fetch port was served last.
  assign d_win = d_req && ((DATA_PRIORITY != 0) || !bus.i_readM || !rr_d_last_reg);

  assign bus.i_stall = bus.i_readM & ~bus.i_valid;
  assign bus.d_stall = d_req & ~bus.d_valid;

  generate
    if (TIMEOUT != 0) begin : g_timeout
      // tcnt_reg counts completed access cycles, so this is the TIMEOUT-th strobe cycle.
      assign acc_timeout = (tcnt_reg == 8'(TIMEOUT - 1));
    end else begin : g_no_timeout
      assign acc_timeout = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      tcnt_reg        <= '0;
      served_d_reg    <= 1'b0;
      rr_d_last_reg   <= 1'b1;
      bus.mem_readM   <= 1'b0;
      bus.mem_writeM  <= 1'b0;
      bus.mem_address <= '0;
      bus.mem_wdata   <= '0;
      bus.i_rdata     <= '0;
      bus.d_rdata     <= '0;
      bus.i_valid     <= 1'b0;
      bus.d_valid     <= 1'b0;
      bus.mem_err     <= 1'b0;
    end else begin
      bus.i_valid <= 1'b0;
      bus.d_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (d_win) begin
            state_reg       <= D_ACC;
            served_d_reg    <= 1'b1;
            tcnt_reg        <= '0;
            bus.mem_writeM  <= bus.d_writeM;
            bus.mem_readM   <= ~bus.d_writeM;
            bus.mem_address <= bus.d_address;
            bus.mem_wdata   <= bus.d_wdata;
          end else if (bus.i_readM) begin
            state_reg       <= I_ACC;
            served_d_reg    <= 1'b0;
            tcnt_reg        <= '0;
            bus.mem_readM   <= 1'b1;
            bus.mem_address <= bus.i_address;
          end
        end
        I_ACC, D_ACC: begin
          tcnt_reg <= tcnt_reg + 8'd1;
          if (bus.mem_ack || acc_timeout) begin
            state_reg      <= RESP;
            bus.mem_readM  <= 1'b0;
            bus.mem_writeM <= 1'b0;
            if (!bus.mem_ack) begin
              bus.mem_err <= 1'b1;
            end
            // A timed-out access still completes with zero data so the CPU never hangs.
            if (served_d_reg) begin
              bus.d_valid <= 1'b1;
              if (!bus.mem_ack) begin
                bus.d_rdata <= '0;
              end else if (bus.mem_readM) begin
                bus.d_rdata <= bus.mem_rdata;
              end
            end else begin
              bus.i_valid <= 1'b1;
              bus.i_rdata <= bus.mem_ack ? bus.mem_rdata : '0;
            end
          end
        end
        RESP: begin
          rr_d_last_reg <= served_d_reg;
          state_reg     <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [15:0] i_cnt_reg;
  logic [15:0] d_cnt_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      i_cnt_reg <= '0;
      d_cnt_reg <= '0;
    end else begin
      if (bus.i_stall && (i_cnt_reg != 16'hFFFF)) i_cnt_reg <= i_cnt_reg + 16'd1;
      if (bus.d_stall && (d_cnt_reg != 16'hFFFF)) d_cnt_reg <= d_cnt_reg + 16'd1;
    end
  end

  assign bus.i_stall_cycles = i_cnt_reg;
  assign bus.d_stall_cycles = d_cnt_reg;
`else
  assign bus.i_stall_cycles = 16'h0000;
  assign bus.d_stall_cycles = 16'h0000;
`endif
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the CPU's instruction-fetch port and data port.
- Generalises the fixed split i/d memory interface of the current CPU top:
  - parametrised word/address width;
  - handshake-based memory with variable latency (ack);
  - selectable fixed-priority or round-robin arbitration;
  - access timeout with sticky error.
- Sits between the datapath memory ports and the external memory. Stall outputs feed the hazard unit.

Parameters:
- WORD_SIZE, 16, data and address width in bits.
- DATA_PRIORITY, 1: 1 = data port always wins ties; 0 = round-robin on ties.
- TIMEOUT, 15: max cycles waiting for mem_ack before abort; 0 disables the timeout; otherwise legal range 1..255.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  synchronous active-low reset.
- i_readM  input  1  instruction fetch request, held until i_valid.
- i_address  input  WORD_SIZE  fetch address.
- i_rdata  output  WORD_SIZE  fetched word, registered.
- i_valid  output  1  one-cycle pulse; i_rdata valid.
- i_stall  output  1  i_readM & ~i_valid.
- d_readM  input  1  data read request, held until d_valid.
- d_writeM  input  1  data write request, held until d_valid.
- d_address  input  WORD_SIZE  data address.
- d_wdata  input  WORD_SIZE  write data.
- d_rdata  output  WORD_SIZE  read word, registered.
- d_valid  output  1  one-cycle pulse; read data valid or write complete.
- d_stall  output  1  (d_readM | d_writeM) & ~d_valid.
- mem_readM  output  1  memory read strobe.
- mem_writeM  output  1  memory write strobe.
- mem_address  output  WORD_SIZE  memory address.
- mem_wdata  output  WORD_SIZE  memory write data.
- mem_rdata  input  WORD_SIZE  memory read data, sampled on mem_ack.
- mem_ack  input  1  memory completes current access this cycle.
- mem_err  output  1  sticky timeout flag.
- i_stall_cycles  output  16  perf counter (see Optional Feature).
- d_stall_cycles  output  16  perf counter (see Optional Feature).

Behaviour:
- States: IDLE, I_ACC, D_ACC, RESP.
- Reset (reset_n=0 at a rising edge):
  - state→IDLE;
  - mem_readM/mem_writeM, mem_address, mem_wdata, i_rdata, d_rdata, i_valid, d_valid, mem_err, counters → 0;
  - round-robin pointer → data-last (instruction wins the first tie);
  - applies mid-access: the strobe drops on that edge and the in-flight access is abandoned, no valid pulse.
- IDLE:
  - Data request pending and (DATA_PRIORITY=1, or no fetch, or RR pointer=instruction-last) → D_ACC.
  - Else fetch pending → I_ACC.
  - On the grant edge: address (and wdata) latch into mem_address/mem_wdata, and mem_readM or mem_writeM asserts.
- d_readM and d_writeM both high: treated as a write; the read is ignored.
- *_ACC:
  - Strobes and address held constant. Timeout counter increments each cycle.
  - mem_ack=1: read → capture mem_rdata into i_rdata/d_rdata. Then strobes drop, go RESP, and the matching valid is asserted for the RESP cycle.
  - No ack and counter reaches TIMEOUT (TIMEOUT≠0):
    - strobes drop; mem_err sets (sticky until reset);
    - go RESP with valid pulsed and rdata=0, so the CPU never deadlocks.
- RESP:
  - Exactly one cycle; no new grant considered (requestor deasserts or re-requests after).
  - → IDLE. RR pointer records the port just served.
- Minimum latency: request seen in IDLE at cycle N → strobe cycle N+1 → ack at N+1 → valid at N+2. With no contention, each access occupies ≥3 cycles.
- Requests withdrawn mid-access: access completes on memory; valid still pulses; no error.
- mem_ack in IDLE/RESP: ignored.
- Address/data changing after grant: ignored; the latched values are used.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- Defined:
  - i_stall_cycles increments every cycle i_stall=1; d_stall_cycles likewise for d_stall;
  - 16-bit, saturate at 16'hFFFF; cleared by reset.
- Undefined: both outputs constant 0 and no counter flops are synthesised.
- Arbitration and timing are identical either way.

Test Plan:
- Reset, then a single fetch at 16'h0010 with ack the next cycle and mem_rdata=16'hA5A5 → mem_readM high 1 cycle with mem_address=16'h0010; i_valid pulses with i_rdata=16'hA5A5 two cycles after the request; i_stall high until then.
- Fetch and data write (addr 16'h0200, wdata 16'h1234) raised in the same cycle, DATA_PRIORITY=1 → write served first (mem_writeM, mem_wdata=16'h1234), then the fetch; d_valid precedes i_valid.
- DATA_PRIORITY=0, both ports requesting continuously for 6 accesses → grants alternate I,D,I,D,I,D.
- Memory never acks, TIMEOUT=15 → strobe drops after 15 cycles; d_valid pulses with d_rdata=0; mem_err=1 and stays 1; the next access still works.
- reset_n low during D_ACC → strobe 0 on that edge; no d_valid; state IDLE; a subsequent fetch completes normally.
- ARB_PERF_CNT_EN defined, data port blocked for 5 stall cycles → d_stall_cycles=5. Forced saturation → holds 16'hFFFF. With the macro undefined, both counters read 0.
